fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit_instr_queue.sv | 51 +++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: FSM state encoding, queue entry layout
// and the sequential PC increment.
package fetch_pkg;

    localparam int FETCH_WIDTH = 32;
    localparam int PC_STEP     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: PC register load port, instruction-memory read port,
// redirect input and the decode-facing queue handshake.
// master = fetch controller side, slave = surrounding pipeline/memory side.
interface fetch_unit_if #(
    parameter int width = 32
);
    logic [width-1:0] pc_i;
    logic             pc_load_o;
    logic [width-1:0] pc_next_o;
    logic             imem_read_o;
    logic [width-1:0] imem_addr_o;
    logic             imem_resp_i;
    logic [width-1:0] imem_rdata_i;
    logic             redirect_i;
    logic [width-1:0] redirect_pc_i;
    logic             iq_valid_o;
    logic [width-1:0] iq_instr_o;
    logic [width-1:0] iq_pc_o;
    logic             iq_ready_i;

    modport master (
        input  pc_i,
        output pc_load_o, pc_next_o,
        output imem_read_o, imem_addr_o,
        input  imem_resp_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output iq_valid_o, iq_instr_o, iq_pc_o,
        input  iq_ready_i
    );

    modport slave (
        output pc_i,
        input  pc_load_o, pc_next_o,
        input  imem_read_o, imem_addr_o,
        output imem_resp_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  iq_valid_o, iq_instr_o, iq_pc_o,
        output iq_ready_i
    );
endinterface

// File: rtl/fetch_unit_instr_queue.sv
// Circular instruction queue holding {pc, instr} pairs between fetch and
// decode. Flush has priority over push and pop. Head reads as zero when empty.
module instr_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  iq_entry_t              push_data,
    input  logic                   pop,
    output iq_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    iq_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; a flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Entry storage; no reset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch controller: issues instruction-memory reads from the external PC
// register, advances or redirects that register and queues returned words.
// Optional build macro FETCH_BYPASS_EN: a response arriving while the queue
// is empty is presented to decode in the same cycle (zero latency).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no read outstanding; issue from pc_i when the queue has room
// REQ     | read outstanding at req_addr; response is enqueued
// DISCARD | read outstanding for a killed path; response is dropped
//
// Memory-side outputs are decoded from the registered state so the first
// read can go out in the first cycle after reset.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int width    = FETCH_WIDTH,
    parameter int IQ_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(IQ_DEPTH) + 1;

    fetch_state_t     state;
    logic [width-1:0] req_addr;
    logic [CW-1:0]    q_count;
    logic             q_full;
    logic             q_empty;
    logic             q_valid;
    logic             q_push;
    logic             q_pop;
    iq_entry_t        q_head;
    iq_entry_t        q_wdata;
    logic             accept;
    logic             room_issue;
    logic             room_next;
    logic [CW:0]      occ_next;

    assign accept     = !rst && (state == REQ) && bus.imem_resp_i && !bus.redirect_i;
    assign q_valid    = !q_empty;
    assign q_pop      = !rst && q_valid && bus.iq_ready_i && !bus.redirect_i;
    assign q_wdata    = '{pc: req_addr, instr: bus.imem_rdata_i};
    // In IDLE nothing can be pushed, so room reduces to "not full or popping".
    assign room_issue = !q_full || q_pop;
    assign occ_next   = {1'b0, q_count} + {{CW{1'b0}}, q_push} - {{CW{1'b0}}, q_pop};
    assign room_next  = occ_next < (CW+1)'(IQ_DEPTH);

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass         = q_empty && accept;
    assign q_push         = accept && !(bypass && bus.iq_ready_i);
    assign bus.iq_valid_o = q_valid || bypass;
    assign bus.iq_pc_o    = q_valid ? q_head.pc    : (bypass ? req_addr : '0);
    assign bus.iq_instr_o = q_valid ? q_head.instr : (bypass ? bus.imem_rdata_i : '0);
`else
    assign q_push         = accept;
    assign bus.iq_valid_o = q_valid;
    assign bus.iq_pc_o    = q_head.pc;
    assign bus.iq_instr_o = q_head.instr;
`endif

    instr_queue #(.DEPTH(IQ_DEPTH)) u_iq (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_i),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Memory request and PC-register load strobes decoded from the state.
    always_comb begin
        bus.imem_read_o = 1'b0;
        bus.imem_addr_o = '0;
        bus.pc_load_o   = 1'b0;
        bus.pc_next_o   = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.redirect_i) begin
                        bus.pc_load_o = 1'b1;
                        bus.pc_next_o = bus.redirect_pc_i;
                    end else if (room_issue) begin
                        bus.imem_read_o = 1'b1;
                        bus.imem_addr_o = bus.pc_i;
                    end
                end
                REQ, DISCARD: begin
                    // The outstanding address must be held until the response.
                    bus.imem_read_o = 1'b1;
                    bus.imem_addr_o = req_addr;
                    if (bus.redirect_i) begin
                        bus.pc_load_o = 1'b1;
                        bus.pc_next_o = bus.redirect_pc_i;
                    end else if (accept) begin
                        bus.pc_load_o = 1'b1;
                        bus.pc_next_o = req_addr + width'(PC_STEP);
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch FSM and outstanding-request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.redirect_i && room_issue) begin
                        req_addr <= bus.pc_i;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.redirect_i) begin
                        state <= bus.imem_resp_i ? IDLE : DISCARD;
                    end else if (bus.imem_resp_i) begin
                        if (room_next) req_addr <= req_addr + width'(PC_STEP);
                        else           state    <= IDLE;
                    end
                end
                DISCARD: begin
                    if (bus.imem_resp_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle expectations for the
// streaming case plus hand-written backpressure, redirect and wrap sequences.
// Environment models: external PC register and a fixed-latency memory whose
// data word is addr ^ 0x73.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.width(32)) bus ();

    fetch_unit #(.width(32), .IQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic [31:0] pc_reg;
    logic [31:0] pc_init = 32'h60;
    int          lat = 1;
    int          mcnt;

    assign bus.pc_i         = pc_reg;
    assign bus.imem_resp_i  = bus.imem_read_o && (mcnt >= lat);
    assign bus.imem_rdata_i = bus.imem_addr_o ^ 32'h73;

    always @(posedge clk) begin
        if (rst)                pc_reg <= pc_init;
        else if (bus.pc_load_o) pc_reg <= bus.pc_next_o;
    end

    always @(posedge clk) begin
        if (rst || !bus.imem_read_o) mcnt <= 0;
        else if (bus.imem_resp_i)    mcnt <= 1;
        else                         mcnt <= mcnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] pc0, input int l, input logic rdy);
        @(negedge clk);
        rst               = 1'b1;
        pc_init           = pc0;
        lat               = l;
        bus.iq_ready_i    = rdy;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        read;
        logic [31:0] addr;
        logic        load;
        logic [31:0] nxt;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] instr;
    } vec_t;

    function automatic vec_t mk(logic rdy, logic rd, logic [31:0] a, logic ld, logic [31:0] n,
                                logic v, logic [31:0] p, logic [31:0] i);
        vec_t r;
        r.ready = rdy; r.read = rd; r.addr = a; r.load = ld; r.nxt = n;
        r.valid = v;   r.ipc = p;   r.instr = i;
        return r;
    endfunction

    vec_t        vt [5];
    logic [31:0] gotq [$];
    int          loads;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Streaming from 0x60, 1-cycle memory, decode always ready.
        vt[0] = mk(1, 1, 32'h60, 0, 32'h0,  0, 32'h0,  32'h0);
`ifdef FETCH_BYPASS_EN
        vt[1] = mk(1, 1, 32'h60, 1, 32'h64, 1, 32'h60, 32'h13);
        vt[2] = mk(1, 1, 32'h64, 1, 32'h68, 1, 32'h64, 32'h17);
        vt[3] = mk(1, 1, 32'h68, 1, 32'h6c, 1, 32'h68, 32'h1b);
        vt[4] = mk(1, 1, 32'h6c, 1, 32'h70, 1, 32'h6c, 32'h1f);
`else
        vt[1] = mk(1, 1, 32'h60, 1, 32'h64, 0, 32'h0,  32'h0);
        vt[2] = mk(1, 1, 32'h64, 1, 32'h68, 1, 32'h60, 32'h13);
        vt[3] = mk(1, 1, 32'h68, 1, 32'h6c, 1, 32'h64, 32'h17);
        vt[4] = mk(1, 1, 32'h6c, 1, 32'h70, 1, 32'h68, 32'h1b);
`endif

        // Outputs held at zero during reset.
        bus.iq_ready_i    = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst read",  bus.imem_read_o, 0);
        chk("rst addr",  bus.imem_addr_o, 0);
        chk("rst load",  bus.pc_load_o,   0);
        chk("rst next",  bus.pc_next_o,   0);
        chk("rst valid", bus.iq_valid_o,  0);
        chk("rst instr", bus.iq_instr_o,  0);
        chk("rst pc",    bus.iq_pc_o,     0);

        do_reset(32'h60, 1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            bus.iq_ready_i = vt[k].ready;
            #1;
            chk($sformatf("tbl[%0d] read", k),  bus.imem_read_o, vt[k].read);
            chk($sformatf("tbl[%0d] addr", k),  bus.imem_addr_o, vt[k].addr);
            chk($sformatf("tbl[%0d] load", k),  bus.pc_load_o,   vt[k].load);
            chk($sformatf("tbl[%0d] next", k),  bus.pc_next_o,   vt[k].nxt);
            chk($sformatf("tbl[%0d] valid", k), bus.iq_valid_o,  vt[k].valid);
            chk($sformatf("tbl[%0d] ipc", k),   bus.iq_pc_o,     vt[k].ipc);
            chk($sformatf("tbl[%0d] instr", k), bus.iq_instr_o,  vt[k].instr);
        end

        // Backpressure: exactly IQ_DEPTH responses taken, then fetch stalls.
        do_reset(32'h60, 1, 1'b0);
        loads = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.pc_load_o) loads++;
        end
        chk("bp loads", loads, 4);
        chk("bp read stalled", bus.imem_read_o, 0);
        chk("bp head valid", bus.iq_valid_o, 1);
        chk("bp head pc", bus.iq_pc_o, 32'h60);
        @(negedge clk);
        bus.iq_ready_i = 1'b1;
        #1;
        chk("bp resume read", bus.imem_read_o, 1);
        chk("bp resume addr", bus.imem_addr_o, 32'h70);
        gotq.delete();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.iq_valid_o && bus.iq_ready_i) gotq.push_back(bus.iq_pc_o);
        end
        chk("bp pop count", gotq.size(), 8);
        for (int i = 0; i < gotq.size(); i++)
            chk($sformatf("bp pop[%0d]", i), gotq[i], 32'h60 + 32'(4 * i));

        // Redirect while a 3-cycle read at 0x80 is outstanding.
        do_reset(32'h80, 3, 1'b0);
        #1;
        chk("rd0 addr", bus.imem_addr_o, 32'h80);
        @(negedge clk);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        #1;
        chk("rd1 read", bus.imem_read_o, 1);
        chk("rd1 addr", bus.imem_addr_o, 32'h80);
        chk("rd1 load", bus.pc_load_o, 1);
        chk("rd1 next", bus.pc_next_o, 32'h200);
        @(negedge clk);
        bus.redirect_i = 1'b0;
        #1;
        chk("rd2 hold addr", bus.imem_addr_o, 32'h80);
        chk("rd2 valid", bus.iq_valid_o, 0);
        @(negedge clk);
        #1;
        chk("rd3 resp dropped load", bus.pc_load_o, 0);
        chk("rd3 hold addr", bus.imem_addr_o, 32'h80);
        @(negedge clk);
        #1;
        chk("rd4 read", bus.imem_read_o, 1);
        chk("rd4 addr", bus.imem_addr_o, 32'h200);
        chk("rd4 valid", bus.iq_valid_o, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("rd7 valid", bus.iq_valid_o, 1);
        chk("rd7 pc", bus.iq_pc_o, 32'h200);

        // Redirect coinciding with the response for 0x84.
        do_reset(32'h80, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        #1;
        chk("rs2 addr", bus.imem_addr_o, 32'h84);
        chk("rs2 load", bus.pc_load_o, 1);
        chk("rs2 next", bus.pc_next_o, 32'h200);
        @(negedge clk);
        bus.redirect_i = 1'b0;
        #1;
        chk("rs3 valid", bus.iq_valid_o, 0);
        chk("rs3 read", bus.imem_read_o, 1);
        chk("rs3 addr", bus.imem_addr_o, 32'h200);
        repeat (2) @(negedge clk);
        #1;
        chk("rs5 pc", bus.iq_pc_o, 32'h200);
        chk("rs5 instr", bus.iq_instr_o, 32'h273);

        // Address wrap at the top of the address space.
        do_reset(32'hFFFF_FFFC, 1, 1'b1);
        @(negedge clk);
        #1;
        chk("wrap load", bus.pc_load_o, 1);
        chk("wrap next", bus.pc_next_o, 32'h0);
        @(negedge clk);
        #1;
        chk("wrap read", bus.imem_read_o, 1);
        chk("wrap addr", bus.imem_addr_o, 32'h0);

        // First response into an empty queue.
        do_reset(32'h60, 1, 1'b1);
        @(negedge clk);
        #1;
`ifdef FETCH_BYPASS_EN
        chk("byp valid", bus.iq_valid_o, 1);
        chk("byp instr", bus.iq_instr_o, 32'h13);
        chk("byp pc", bus.iq_pc_o, 32'h60);
        @(negedge clk);
        #1;
        chk("byp next pc", bus.iq_pc_o, 32'h64);
`else
        chk("nobyp valid", bus.iq_valid_o, 0);
        @(negedge clk);
        #1;
        chk("nobyp pc", bus.iq_pc_o, 32'h60);
        chk("nobyp instr", bus.iq_instr_o, 32'h13);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
